led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_pkg.sv | 25 ++
 rtl/led_if.sv | 26 ++
 rtl/led_next_sel.sv | 43 ++++
 rtl/led_sequencer.sv | 169 ++++++++++++++++
 tb/tb_led_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared types and sizing helpers for the LED pattern sequencer.
package led_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2
   } led_state_e;

   localparam int LED_W       = 18;
   localparam int DEF_N_PAT   = 4;
   localparam int DEF_TIMEOUT = 1023;

   // Timer must be able to hold TIMEOUT-1, the last RUN cycle index.
   function automatic int tmr_width(input int timeout);
      return (timeout < 2) ? 1 : $clog2(timeout + 1);
   endfunction

   function automatic int idx_width(input int n_pat);
      return (n_pat < 2) ? 1 : $clog2(n_pat);
   endfunction

   localparam int DEF_TMR_W = tmr_width(DEF_TIMEOUT);

endpackage

// File: rtl/led_if.sv
// Pattern-block bus of the LED sequencer: run control, pattern data/done flags and status.
interface led_if
   import led_pkg::*;
#(
   parameter int N_PAT = DEF_N_PAT
);
   logic                     enabler;
   logic [N_PAT-1:0]         pat_mask;
   logic [LED_W*N_PAT-1:0]   pat_out;
   logic [N_PAT-1:0]         pat_over;
   logic [N_PAT-1:0]         pat_begin;
   logic [LED_W-1:0]         out;
   logic                     cycle_done;
   logic [7:0]               loop_cnt;
   logic                     timeout_err;

   modport master (
      output enabler, pat_mask, pat_out, pat_over,
      input  pat_begin, out, cycle_done, loop_cnt, timeout_err
   );

   modport slave (
      input  enabler, pat_mask, pat_out, pat_over,
      output pat_begin, out, cycle_done, loop_cnt, timeout_err
   );
endinterface

// File: rtl/led_next_sel.sv
// Cyclic next-set-bit picker: lowest mask bit above cur, else lowest overall (wrap).
module led_next_sel
   import led_pkg::*;
#(
   parameter int N_PAT = DEF_N_PAT,
   parameter int IDX_W = idx_width(N_PAT)
) (
   input  logic [N_PAT-1:0] mask,
   input  logic [IDX_W-1:0] cur,
   output logic [IDX_W-1:0] nxt,
   output logic             wrap,
   output logic             none
);

   logic             found_hi_s;
   logic [IDX_W-1:0] hi_idx_s;
   logic [IDX_W-1:0] lo_idx_s;

   // Descending scan so the last hit written is the lowest qualifying index.
   always_comb begin
      found_hi_s = 1'b0;
      hi_idx_s   = '0;
      lo_idx_s   = '0;
      for (int i = N_PAT - 1; i >= 0; i--) begin
         lo_idx_s   = mask[i] ? IDX_W'(i) : lo_idx_s;
         hi_idx_s   = (mask[i] && (i > int'(cur))) ? IDX_W'(i) : hi_idx_s;
         found_hi_s = (mask[i] && (i > int'(cur))) ? 1'b1 : found_hi_s;
      end
   end

   // Final selection and flags.
   always_comb begin
      none = ~|mask;
      if (found_hi_s) begin
         nxt  = hi_idx_s;
         wrap = 1'b0;
      end else begin
         nxt  = lo_idx_s;
         wrap = ~none;
      end
   end

endmodule

// File: rtl/led_sequencer.sv
// Rotates through enabled LED pattern blocks (IDLE/RUN/GAP), with per-pattern timeout
// and rotation counting; all outputs are registered.
module led_sequencer
   import led_pkg::*;
#(
   parameter int N_PAT   = DEF_N_PAT,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic async_rs_n,
   led_if.slave bus
);

   localparam int IDX_W = idx_width(N_PAT);
   localparam int TMR_W = tmr_width(TIMEOUT);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_RUN  = ST_RUN;
   localparam logic [1:0] S_GAP  = ST_GAP;

   logic [1:0]       rst_sync_r;
   logic [1:0]       state_r;
   logic [IDX_W-1:0] cur_r;
   logic [TMR_W-1:0] timer_r;
   logic [N_PAT-1:0] pat_begin_r;
   logic [LED_W-1:0] out_r;
   logic             cycle_done_r;
   logic [7:0]       loop_cnt_r;
   logic             timeout_err_r;

   logic [1:0]       state_nxt_s;
   logic [IDX_W-1:0] cur_nxt_s;
   logic [TMR_W-1:0] timer_nxt_s;
   logic             wrap_pulse_s;
   logic             tmo_set_s;
   logic [N_PAT-1:0] pat_begin_nxt_s;
   logic [LED_W-1:0] out_nxt_s;
   logic             run_ok_s;
   logic             over_cur_s;
   logic             tmo_hit_s;
   logic [IDX_W-1:0] sel_cur_s;
   logic [IDX_W-1:0] sel_idx_s;
   logic             sel_wrap_s;
   logic             sel_none_s;

   // From IDLE the picker starts above the top index, which yields the lowest set bit.
   assign sel_cur_s  = (state_r == S_GAP) ? cur_r : IDX_W'(N_PAT - 1);
   assign run_ok_s   = rst_sync_r[1];
   assign over_cur_s = bus.pat_over[cur_r];
   assign tmo_hit_s  = (timer_r == TMR_W'(TIMEOUT - 1));

   led_next_sel #(
      .N_PAT (N_PAT),
      .IDX_W (IDX_W)
   ) u_next_sel (
      .mask (bus.pat_mask),
      .cur  (sel_cur_s),
      .nxt  (sel_idx_s),
      .wrap (sel_wrap_s),
      .none (sel_none_s)
   );

   // Reset release synchroniser; holds the FSM in IDLE until two edges after release.
   always_ff @(posedge clk or negedge async_rs_n) begin
      if (!async_rs_n) begin
         rst_sync_r <= 2'b00;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b1};
      end
   end

   // Next-state, index and timer decision.
   always_comb begin
      state_nxt_s  = state_r;
      cur_nxt_s    = cur_r;
      timer_nxt_s  = timer_r;
      wrap_pulse_s = 1'b0;
      tmo_set_s    = 1'b0;
      if (!bus.enabler) begin
         state_nxt_s = S_IDLE;
         timer_nxt_s = '0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (run_ok_s && !sel_none_s) begin
                  state_nxt_s = S_RUN;
                  cur_nxt_s   = sel_idx_s;
                  timer_nxt_s = '0;
               end else begin
                  state_nxt_s = S_IDLE;
               end
            end
            S_RUN: begin
               // A done flag in the timeout cycle wins, so no error is flagged.
               if (over_cur_s) begin
                  state_nxt_s = S_GAP;
               end else if (tmo_hit_s) begin
                  state_nxt_s = S_GAP;
                  tmo_set_s   = 1'b1;
               end else begin
                  timer_nxt_s = timer_r + TMR_W'(1);
               end
            end
            S_GAP: begin
               if (sel_none_s) begin
                  state_nxt_s = S_IDLE;
               end else begin
                  state_nxt_s  = S_RUN;
                  cur_nxt_s    = sel_idx_s;
                  timer_nxt_s  = '0;
                  wrap_pulse_s = sel_wrap_s;
               end
            end
            default: begin
               state_nxt_s = S_IDLE;
               cur_nxt_s   = '0;
               timer_nxt_s = '0;
            end
         endcase
      end
   end

   // Output values for the coming cycle, derived from the next state.
   always_comb begin
      pat_begin_nxt_s = '0;
      out_nxt_s       = '0;
      if (state_nxt_s == S_RUN) begin
         pat_begin_nxt_s = N_PAT'(1'b1) << cur_nxt_s;
         out_nxt_s       = bus.pat_out[int'(cur_nxt_s) * LED_W +: LED_W];
      end else begin
         pat_begin_nxt_s = '0;
         out_nxt_s       = '0;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge async_rs_n) begin
      if (!async_rs_n) begin
         state_r       <= S_IDLE;
         cur_r         <= '0;
         timer_r       <= '0;
         pat_begin_r   <= '0;
         out_r         <= '0;
         cycle_done_r  <= 1'b0;
         loop_cnt_r    <= 8'd0;
         timeout_err_r <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         cur_r         <= cur_nxt_s;
         timer_r       <= timer_nxt_s;
         pat_begin_r   <= pat_begin_nxt_s;
         out_r         <= out_nxt_s;
         cycle_done_r  <= wrap_pulse_s;
         timeout_err_r <= timeout_err_r | tmo_set_s;
         if (wrap_pulse_s) begin
            loop_cnt_r <= loop_cnt_r + 8'd1;
         end else begin
            loop_cnt_r <= loop_cnt_r;
         end
      end
   end

   assign bus.pat_begin   = pat_begin_r;
   assign bus.out         = out_r;
   assign bus.cycle_done  = cycle_done_r;
   assign bus.loop_cnt    = loop_cnt_r;
   assign bus.timeout_err = timeout_err_r;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: a cycle table plus hand sequences, on a default
// instance (a) and a TIMEOUT=15 instance (b) sharing inputs.
module tb_led_sequencer;

   localparam logic [17:0] P0 = 18'h00FFF;
   localparam logic [17:0] P1 = 18'h0F0F0;
   localparam logic [17:0] P2 = 18'h15555;
   localparam logic [17:0] P3 = 18'h2AAAA;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [3:0]  mask;
   logic [3:0]  over;
   logic [71:0] pout;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        en;
      logic [3:0]  mask;
      logic [3:0]  over;
      logic [3:0]  pb;
      logic [17:0] out;
      logic        cd;
      logic [7:0]  lc;
      logic        te;
   } vec_t;

   vec_t tbl [0:21];

   led_if #(.N_PAT(4)) if_a ();
   led_if #(.N_PAT(4)) if_b ();

   assign if_a.enabler  = en;
   assign if_a.pat_mask = mask;
   assign if_a.pat_out  = pout;
   assign if_a.pat_over = over;
   assign if_b.enabler  = en;
   assign if_b.pat_mask = mask;
   assign if_b.pat_out  = pout;
   assign if_b.pat_over = over;

   led_sequencer #(.N_PAT(4)) dut_a (
      .clk        (clk),
      .async_rs_n (rst_n),
      .bus        (if_a.slave)
   );

   led_sequencer #(.N_PAT(4), .TIMEOUT(15)) dut_b (
      .clk        (clk),
      .async_rs_n (rst_n),
      .bus        (if_b.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      en    = 1'b0;
      mask  = 4'b0000;
      over  = 4'b0000;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
   endtask

   function automatic logic [17:0] exp_out(input logic [3:0] pb);
      case (pb)
         4'b0001: return P0;
         4'b0010: return P1;
         4'b0100: return P2;
         4'b1000: return P3;
         default: return 18'h00000;
      endcase
   endfunction

   logic [3:0] pb;
   logic [3:0] prev_pb;
   int starts [0:7];
   int lens   [0:7];
   int gaps   [0:7];
   int nstart, run_len, gap_cnt, cd_cnt, trk_err, cd_at_wrap, n, edges, cdn;
   logic found;

   initial begin
      pout  = {P3, P2, P1, P0};
      en    = 1'b0;
      mask  = 4'b0000;
      over  = 4'b0000;
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         starts[k] = 0; lens[k] = 0; gaps[k] = 0;
      end

      //            en    mask     over     pb       out  cd    lc     te
      tbl[0]  = '{1'b1, 4'b0101, 4'b0000, 4'b0001, P0,   1'b0, 8'd0, 1'b0};
      tbl[1]  = '{1'b1, 4'b0101, 4'b0000, 4'b0001, P0,   1'b0, 8'd0, 1'b0};
      tbl[2]  = '{1'b1, 4'b0101, 4'b0001, 4'b0000, 18'h0, 1'b0, 8'd0, 1'b0};
      tbl[3]  = '{1'b1, 4'b0101, 4'b0000, 4'b0100, P2,   1'b0, 8'd0, 1'b0};
      tbl[4]  = '{1'b1, 4'b0101, 4'b0100, 4'b0000, 18'h0, 1'b0, 8'd0, 1'b0};
      tbl[5]  = '{1'b1, 4'b0101, 4'b0000, 4'b0001, P0,   1'b1, 8'd1, 1'b0};
      tbl[6]  = '{1'b1, 4'b0101, 4'b0100, 4'b0001, P0,   1'b0, 8'd1, 1'b0};
      tbl[7]  = '{1'b1, 4'b0100, 4'b0001, 4'b0000, 18'h0, 1'b0, 8'd1, 1'b0};
      tbl[8]  = '{1'b1, 4'b0100, 4'b0000, 4'b0100, P2,   1'b0, 8'd1, 1'b0};
      tbl[9]  = '{1'b1, 4'b0100, 4'b0100, 4'b0000, 18'h0, 1'b0, 8'd1, 1'b0};
      tbl[10] = '{1'b1, 4'b0100, 4'b0100, 4'b0100, P2,   1'b1, 8'd2, 1'b0};
      tbl[11] = '{1'b1, 4'b0100, 4'b0100, 4'b0000, 18'h0, 1'b0, 8'd2, 1'b0};
      tbl[12] = '{1'b1, 4'b0100, 4'b0000, 4'b0100, P2,   1'b1, 8'd3, 1'b0};
      tbl[13] = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 18'h0, 1'b0, 8'd3, 1'b0};
      tbl[14] = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 18'h0, 1'b0, 8'd3, 1'b0};
      tbl[15] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 18'h0, 1'b0, 8'd3, 1'b0};
      tbl[16] = '{1'b1, 4'b1010, 4'b0000, 4'b0010, P1,   1'b0, 8'd3, 1'b0};
      tbl[17] = '{1'b1, 4'b0000, 4'b0000, 4'b0010, P1,   1'b0, 8'd3, 1'b0};
      tbl[18] = '{1'b1, 4'b0000, 4'b0010, 4'b0000, 18'h0, 1'b0, 8'd3, 1'b0};
      tbl[19] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 18'h0, 1'b0, 8'd3, 1'b0};
      tbl[20] = '{1'b1, 4'b1000, 4'b0000, 4'b1000, P3,   1'b0, 8'd3, 1'b0};
      tbl[21] = '{1'b0, 4'b1000, 4'b0000, 4'b0000, 18'h0, 1'b0, 8'd3, 1'b0};

      // Power-on reset
      #2 rst_n = 1'b0;
      tick();
      tick();
      check("rst_pb_a", if_a.pat_begin, 4'b0000);
      check("rst_out_a", if_a.out, 18'h0);
      check("rst_cd_a", if_a.cycle_done, 1'b0);
      check("rst_lc_a", if_a.loop_cnt, 8'd0);
      check("rst_te_a", if_a.timeout_err, 1'b0);
      check("rst_pb_b", if_b.pat_begin, 4'b0000);
      rst_n = 1'b1;
      repeat (3) tick();

      // Cycle table on instance b
      for (int i = 0; i < 22; i++) begin
         en   = tbl[i].en;
         mask = tbl[i].mask;
         over = tbl[i].over;
         tick();
         check($sformatf("row%0d_pb", i), if_b.pat_begin, tbl[i].pb);
         check($sformatf("row%0d_out", i), if_b.out, tbl[i].out);
         check($sformatf("row%0d_cd", i), if_b.cycle_done, tbl[i].cd);
         check($sformatf("row%0d_lc", i), if_b.loop_cnt, tbl[i].lc);
         check($sformatf("row%0d_te", i), if_b.timeout_err, tbl[i].te);
      end

      // Normal rotation on instance a: each pattern done after 20 RUN cycles
      do_reset();
      en = 1'b1; mask = 4'b1111; over = 4'b0000;
      nstart = 0; run_len = 0; gap_cnt = 0; cd_cnt = 0; trk_err = 0; cd_at_wrap = 0;
      prev_pb = 4'b0000;
      for (int cyc = 0; cyc < 200 && nstart < 5; cyc++) begin
         tick();
         pb = if_a.pat_begin;
         if ($countones(pb) > 1 || if_a.out !== exp_out(pb)) trk_err++;
         if (if_a.cycle_done) cd_cnt++;
         if (pb != 4'b0000) begin
            if (prev_pb == 4'b0000) begin
               if (nstart > 0) gaps[nstart-1] = gap_cnt;
               if (nstart == 4) cd_at_wrap = int'(if_a.cycle_done);
               starts[nstart] = int'(pb);
               run_len = 0;
               nstart++;
            end
            run_len++;
            lens[nstart-1] = run_len;
         end else begin
            if (prev_pb != 4'b0000) gap_cnt = 0;
            gap_cnt++;
         end
         prev_pb = pb;
         over = (run_len == 20 && pb != 4'b0000) ? pb : 4'b0000;
      end
      check("s1_run_starts", nstart, 5);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("s1_pb_order%0d", k), starts[k], 1 << k);
         check($sformatf("s1_run_len%0d", k), lens[k], 20);
         check($sformatf("s1_gap_len%0d", k), gaps[k], 1);
      end
      check("s1_restart_p0", starts[4], 1);
      check("s1_cd_count", cd_cnt, 1);
      check("s1_cd_at_wrap", cd_at_wrap, 1);
      check("s1_loop_cnt", if_a.loop_cnt, 8'd1);
      check("s1_out_track", trk_err, 0);

      // Enable drop mid-RUN of pattern 1
      for (int cyc = 0; cyc < 60 && if_a.pat_begin != 4'b0010; cyc++) begin
         tick();
         run_len = (if_a.pat_begin == prev_pb) ? run_len + 1 : 1;
         prev_pb = if_a.pat_begin;
         over = (run_len == 20 && prev_pb != 4'b0000) ? prev_pb : 4'b0000;
      end
      check("s4_pat1_running", if_a.pat_begin, 4'b0010);
      tick();
      en = 1'b0;
      tick();
      check("s4_drop_pb", if_a.pat_begin, 4'b0000);
      check("s4_drop_out", if_a.out, 18'h0);
      check("s4_drop_lc", if_a.loop_cnt, 8'd1);
      en = 1'b1; over = 4'b0000;
      tick();
      check("s4_reen_pb", if_a.pat_begin, 4'b0001);
      check("s4_reen_out", if_a.out, P0);
      check("s4_reen_lc", if_a.loop_cnt, 8'd1);

      // Done flag in the very cycle the timeout is reached (instance b, TIMEOUT=15)
      do_reset();
      en = 1'b1; mask = 4'b0001; over = 4'b0000;
      tick();
      repeat (14) tick();
      check("s6_cycle15_run", if_b.pat_begin, 4'b0001);
      over = 4'b0001;
      tick();
      check("s6_same_gap", if_b.pat_begin, 4'b0000);
      check("s6_same_te", if_b.timeout_err, 1'b0);

      // Timeout of pattern 1
      do_reset();
      en = 1'b1; mask = 4'b1111; over = 4'b0001;
      tick();
      tick();
      over = 4'b0000;
      tick();
      check("s3_p1_start", if_b.pat_begin, 4'b0010);
      n = 1;
      found = 1'b0;
      for (int cyc = 0; cyc < 40 && !found; cyc++) begin
         tick();
         if (if_b.pat_begin == 4'b0010) n++;
         else found = 1'b1;
      end
      check("s3_run_len", n, 15);
      check("s3_gap_pb", if_b.pat_begin, 4'b0000);
      check("s3_te_set", if_b.timeout_err, 1'b1);
      tick();
      check("s3_p2_next", if_b.pat_begin, 4'b0100);
      over = 4'b0100;
      tick();
      check("s3_te_sticky", if_b.timeout_err, 1'b1);

      // Build a wrap so the reset has non-zero status to clear
      over = 4'b1111;
      found = 1'b0;
      for (int cyc = 0; cyc < 10 && !found; cyc++) begin
         tick();
         if (if_b.pat_begin == 4'b0001 && if_b.loop_cnt == 8'd1) found = 1'b1;
      end
      over = 4'b0000;
      check("s5_pre_wrap", found, 1'b1);
      tick();
      check("s5_pre_run", if_b.pat_begin, 4'b0001);

      // Reset pulse between clock edges
      #2 rst_n = 1'b0;
      #1;
      check("s5_async_pb", if_b.pat_begin, 4'b0000);
      check("s5_async_out", if_b.out, 18'h0);
      check("s5_async_lc", if_b.loop_cnt, 8'd0);
      check("s5_async_te", if_b.timeout_err, 1'b0);
      check("s5_async_cd", if_b.cycle_done, 1'b0);
      #1 rst_n = 1'b1;
      tick();
      check("s5_edge1_idle", if_b.pat_begin, 4'b0000);
      edges = 1;
      for (int cyc = 0; cyc < 8 && if_b.pat_begin == 4'b0000; cyc++) begin
         tick();
         edges++;
      end
      check("s5_restart_pb", if_b.pat_begin, 4'b0001);
      check("s5_restart_late", (edges >= 2), 1'b1);

      // loop_cnt wrap 255 -> 0 with a single one-cycle pattern
      mask = 4'b0001; over = 4'b0001;
      cdn = 0;
      for (int cyc = 0; cyc < 1200 && cdn < 256; cyc++) begin
         tick();
         if (if_b.cycle_done) begin
            cdn++;
            if (cdn == 255) check("wrap_lc255", if_b.loop_cnt, 8'd255);
            if (cdn == 256) check("wrap_lc0", if_b.loop_cnt, 8'd0);
         end
      end
      check("wrap_pulses", cdn, 256);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
